// File: rtl/lynx_flit_pkg.sv
// Shared flit-format definitions for the lynx NoC: control-bit offsets, payload widths
// and the depacketizer state encoding.
package lynx_flit_pkg;

    // Control-bit offsets measured down from the flit MSB.
    localparam int unsigned VALID_BIT = 0;
    localparam int unsigned HEAD_BIT  = 1;
    localparam int unsigned TAIL_BIT  = 2;
    localparam int unsigned CTRL_BITS = 3;

    typedef enum logic [1:0] {
        StIdle,
        StBody,
        StHold
    } state_e;

    function automatic int unsigned head_payload(input int unsigned width_in,
                                                 input int unsigned addr_w,
                                                 input int unsigned vc_w);
        return width_in - CTRL_BITS - addr_w - vc_w;
    endfunction

    function automatic int unsigned body_payload(input int unsigned width_in,
                                                 input int unsigned vc_w);
        return width_in - CTRL_BITS - vc_w;
    endfunction

    function automatic int unsigned num_flits(input int unsigned width_in,
                                              input int unsigned addr_w,
                                              input int unsigned vc_w,
                                              input int unsigned width_out);
        int unsigned hp;
        int unsigned bp;
        hp = head_payload(width_in, addr_w, vc_w);
        bp = body_payload(width_in, vc_w);
        if (width_out <= hp) begin
            return 1;
        end
        return 1 + (width_out - hp + bp - 1) / bp;
    endfunction

endpackage

// File: rtl/flit_field_decode.sv
// Combinational split of one NoC flit into its control bits, VC, dst and payload fields.
module flit_field_decode
    import lynx_flit_pkg::*;
#(
    parameter int unsigned WIDTH_IN         = 36,
    parameter int unsigned ADDRESS_WIDTH    = 4,
    parameter int unsigned VC_ADDRESS_WIDTH = 1,
    localparam int unsigned HP = head_payload(WIDTH_IN, ADDRESS_WIDTH, VC_ADDRESS_WIDTH),
    localparam int unsigned BP = body_payload(WIDTH_IN, VC_ADDRESS_WIDTH)
) (
    input  logic [WIDTH_IN-1:0]         flit_i,
    output logic                        valid_o,
    output logic                        head_o,
    output logic                        tail_o,
    output logic [VC_ADDRESS_WIDTH-1:0] vc_o,
    output logic [ADDRESS_WIDTH-1:0]    dst_o,
    output logic [HP-1:0]               head_pl_o,
    output logic [BP-1:0]               body_pl_o
);

    assign valid_o   = flit_i[WIDTH_IN-1-VALID_BIT];
    assign head_o    = flit_i[WIDTH_IN-1-HEAD_BIT];
    assign tail_o    = flit_i[WIDTH_IN-1-TAIL_BIT];
    assign vc_o      = flit_i[WIDTH_IN-1-CTRL_BITS -: VC_ADDRESS_WIDTH];
    // dst only has meaning on a head flit; on body flits these bits are payload.
    assign dst_o     = flit_i[WIDTH_IN-1-CTRL_BITS-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH];
    assign head_pl_o = flit_i[HP-1:0];
    assign body_pl_o = flit_i[BP-1:0];

endmodule

// File: rtl/depacketizer_3.sv
// Reassembles 1..N-flit NoC packets into one wide word on a valid/ready port, with a sticky
// protocol-error flag. Optional VC filtering is enabled with DEPACKETIZER_VC_FILTER_EN.
module depacketizer_3
    import lynx_flit_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH    = 4,
    parameter int unsigned VC_ADDRESS_WIDTH = 1,
    parameter int unsigned WIDTH_IN         = 36,
    parameter int unsigned WIDTH_OUT        = 92,
    parameter int unsigned ASSIGNED_VC      = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH_IN-1:0]         data_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [WIDTH_OUT-1:0]        data_out,
    output logic [ADDRESS_WIDTH-1:0]    dst_out,
    output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        err_out
);

    localparam int unsigned HP        = head_payload(WIDTH_IN, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
    localparam int unsigned BP        = body_payload(WIDTH_IN, VC_ADDRESS_WIDTH);
    localparam int unsigned NUM_FLITS = num_flits(WIDTH_IN, ADDRESS_WIDTH, VC_ADDRESS_WIDTH,
                                                  WIDTH_OUT);
    localparam int unsigned TOTAL     = HP + (NUM_FLITS - 1) * BP;
    localparam int unsigned CNT_W     = $clog2(NUM_FLITS + 1);
    localparam logic [VC_ADDRESS_WIDTH-1:0] AVC = VC_ADDRESS_WIDTH'(ASSIGNED_VC);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [TOTAL-1:0]            asm_q, asm_d;
    logic [ADDRESS_WIDTH-1:0]    dst_q, dst_d;
    logic [VC_ADDRESS_WIDTH-1:0] vc_q, vc_d;
    logic                        err_q, err_d;

    logic                        f_valid;
    logic                        f_head;
    logic                        f_tail;
    logic [VC_ADDRESS_WIDTH-1:0] f_vc;
    logic [ADDRESS_WIDTH-1:0]    f_dst;
    logic [HP-1:0]               f_head_pl;
    logic [BP-1:0]               f_body_pl;

    logic fire;
    logic vc_bad;
    logic take;
    logic last_body;

    flit_field_decode #(
        .WIDTH_IN        (WIDTH_IN),
        .ADDRESS_WIDTH   (ADDRESS_WIDTH),
        .VC_ADDRESS_WIDTH(VC_ADDRESS_WIDTH)
    ) u_decode (
        .flit_i   (data_in),
        .valid_o  (f_valid),
        .head_o   (f_head),
        .tail_o   (f_tail),
        .vc_o     (f_vc),
        .dst_o    (f_dst),
        .head_pl_o(f_head_pl),
        .body_pl_o(f_body_pl)
    );

    assign ready_out = (state_q != StHold) | ready_in;
    assign valid_out = (state_q == StHold);
    assign fire      = valid_in & ready_out & f_valid;

`ifdef DEPACKETIZER_VC_FILTER_EN
    assign vc_bad = fire & (f_vc != AVC);
`else
    logic [VC_ADDRESS_WIDTH-1:0] unused_avc;
    assign unused_avc = AVC;
    assign vc_bad     = 1'b0;
`endif

    // A foreign-VC flit is swallowed without touching the assembly state.
    assign take = fire & ~vc_bad;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        dst_d     = dst_q;
        vc_d      = vc_q;
        err_d     = err_q | vc_bad;
        last_body = ((32'(cnt_q) + 32'd1) == NUM_FLITS);

        if (state_q == StHold && ready_in) begin
            state_d = StIdle;
        end

        if (take) begin
            if (f_head) begin
                // A head always starts a fresh packet; one arriving mid-packet drops the old one.
                if (state_q == StBody || (f_tail != (NUM_FLITS == 1))) begin
                    err_d = 1'b1;
                end
                asm_d                = '0;
                asm_d[TOTAL-1 -: HP] = f_head_pl;
                dst_d                = f_dst;
                vc_d                 = f_vc;
                cnt_d                = CNT_W'(1);
                state_d              = (f_tail || NUM_FLITS == 1) ? StHold : StBody;
            end else if (state_q == StBody) begin
                for (int k = 1; k < NUM_FLITS; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        asm_d[TOTAL-1-HP-(k-1)*BP -: BP] = f_body_pl;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (f_tail || last_body) begin
                    state_d = StHold;
                    if (f_tail != last_body) begin
                        err_d = 1'b1;
                    end
                end
            end else begin
                // Body flit with no packet open.
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            asm_q   <= '0;
            dst_q   <= '0;
            vc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            dst_q   <= dst_d;
            vc_q    <= vc_d;
            err_q   <= err_d;
        end
    end

    // The last flit is MSB-aligned, so any surplus low bits are padding.
    assign data_out = asm_q[TOTAL-1 -: WIDTH_OUT];
    assign dst_out  = dst_q;
    assign vc_out   = vc_q;
    assign err_out  = err_q;

    if (TOTAL > WIDTH_OUT) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^asm_q[TOTAL-WIDTH_OUT-1:0];
    end

endmodule

// File: tb/tb_depacketizer_3.sv
// Self-checking bench for depacketizer_3: directed scenarios plus randomized packets
// checked against a payload-concatenation reference model.
module tb_depacketizer_3;

    localparam int AW = 4;
    localparam int VW = 1;
    localparam int WI = 36;
    localparam int WO = 92;

    typedef struct packed {
        logic [WO-1:0] d;
        logic [AW-1:0] dst;
        logic [VW-1:0] vc;
    } pkt_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WI-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic [WO-1:0] data_out;
    logic [AW-1:0] dst_out;
    logic [VW-1:0] vc_out;
    logic          valid_out;
    logic          ready_in;
    logic          err_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    depacketizer_3 #(
        .ADDRESS_WIDTH   (AW),
        .VC_ADDRESS_WIDTH(VW),
        .WIDTH_IN        (WI),
        .WIDTH_OUT       (WO),
        .ASSIGNED_VC     (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .dst_out  (dst_out),
        .vc_out   (vc_out),
        .valid_out(valid_out),
        .ready_in (ready_in),
        .err_out  (err_out)
    );

    function automatic logic [WI-1:0] mk_head(input logic tail, input logic [VW-1:0] vc,
                                              input logic [AW-1:0] dst, input logic [27:0] pl);
        return {1'b1, 1'b1, tail, vc, dst, pl};
    endfunction

    function automatic logic [WI-1:0] mk_body(input logic tail, input logic [VW-1:0] vc,
                                              input logic [31:0] pl);
        return {1'b1, 1'b0, tail, vc, pl};
    endfunction

    // Payloads concatenated MSB-first; flits that never arrived contribute zeros.
    function automatic logic [WO-1:0] ref_data(input logic [27:0] h, input logic [31:0] b1,
                                               input logic [31:0] b2, input int nflits);
        logic [31:0] s1;
        logic [31:0] s2;
        s1 = (nflits > 1) ? b1 : 32'h0;
        s2 = (nflits > 2) ? b2 : 32'h0;
        return {h, s1, s2};
    endfunction

    task automatic send(input logic [WI-1:0] f);
        int n;
        n        = 0;
        data_in  = f;
        valid_in = 1'b1;
        #1;
        while (!ready_out && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ready_out) begin
            total++;
            bad++;
            $display("FAIL send_timeout ready_out=%0b want 1", ready_out);
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = '0;
        repeat (2) @(negedge clk);
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", valid_out); end
        total++; if (data_out !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", data_out); end
        total++; if (dst_out !== '0) begin bad++; $display("FAIL rst_dst got=%h want=0", dst_out); end
        total++; if (vc_out !== '0) begin bad++; $display("FAIL rst_vc got=%h want=0", vc_out); end
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", err_out); end
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", ready_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_three_flit();
        ready_in = 1'b1;
        send(mk_head(1'b0, 1'b0, 4'h5, 28'hABCDEF1));
        send(mk_body(1'b0, 1'b0, 32'h12345678));
        send(mk_body(1'b1, 1'b0, 32'h9ABCDEF0));
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL tf_valid got=%0b want=1", valid_out); end
        total++;
        if (data_out !== 92'hABCDEF1_12345678_9ABCDEF0) begin
            bad++; $display("FAIL tf_data got=%h want=%h", data_out, 92'hABCDEF1_12345678_9ABCDEF0);
        end
        total++; if (dst_out !== 4'h5) begin bad++; $display("FAIL tf_dst got=%h want=5", dst_out); end
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL tf_err got=%0b want=0", err_out); end
        @(negedge clk);
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL tf_consumed got=%0b want=0", valid_out); end
    endtask

    task automatic test_backpressure();
        logic [27:0] ha, hb;
        logic [31:0] a1, a2, b1, b2;
        logic [WO-1:0] ea, eb;
        ha = 28'($urandom()); a1 = $urandom(); a2 = $urandom();
        hb = 28'($urandom()); b1 = $urandom(); b2 = $urandom();
        ea = ref_data(ha, a1, a2, 3);
        eb = ref_data(hb, b1, b2, 3);
        ready_in = 1'b0;
        send(mk_head(1'b0, 1'b0, 4'h3, ha));
        send(mk_body(1'b0, 1'b0, a1));
        send(mk_body(1'b1, 1'b0, a2));
        data_in  = mk_head(1'b0, 1'b0, 4'hC, hb);
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%0b want=0", i, ready_out); end
            total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%0b want=1", i, valid_out); end
            total++; if (data_out !== ea) begin bad++; $display("FAIL bp_hold[%0d] got=%h want=%h", i, data_out, ea); end
            total++; if (dst_out !== 4'h3) begin bad++; $display("FAIL bp_dst[%0d] got=%h want=3", i, dst_out); end
            @(negedge clk);
        end
        ready_in = 1'b1;
        #1;
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b want=1", ready_out); end
        @(negedge clk);
        valid_in = 1'b0;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL bp_after got=%0b want=0", valid_out); end
        send(mk_body(1'b0, 1'b0, b1));
        send(mk_body(1'b1, 1'b0, b2));
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL bp2_valid got=%0b want=1", valid_out); end
        total++; if (data_out !== eb) begin bad++; $display("FAIL bp2_data got=%h want=%h", data_out, eb); end
        total++; if (dst_out !== 4'hC) begin bad++; $display("FAIL bp2_dst got=%h want=c", dst_out); end
        @(negedge clk);
    endtask

    task automatic test_body_in_idle();
        logic [27:0] h;
        logic [31:0] b1, b2;
        pulse_reset();
        h = 28'($urandom()); b1 = $urandom(); b2 = $urandom();
        send(mk_body(1'b0, 1'b0, $urandom()));
        for (int i = 0; i < 3; i++) begin
            total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL bi_valid[%0d] got=%0b want=0", i, valid_out); end
            @(negedge clk);
        end
        total++; if (err_out !== 1'b1) begin bad++; $display("FAIL bi_err got=%0b want=1", err_out); end
        send(mk_head(1'b0, 1'b0, 4'h9, h));
        send(mk_body(1'b0, 1'b0, b1));
        send(mk_body(1'b1, 1'b0, b2));
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL bi_pkt_valid got=%0b want=1", valid_out); end
        total++;
        if (data_out !== ref_data(h, b1, b2, 3)) begin
            bad++; $display("FAIL bi_pkt_data got=%h want=%h", data_out, ref_data(h, b1, b2, 3));
        end
        @(negedge clk);
    endtask

    task automatic test_early_tail();
        logic [27:0] h;
        logic [31:0] b1;
        pulse_reset();
        h = 28'($urandom()); b1 = $urandom();
        send(mk_head(1'b0, 1'b0, 4'h2, h));
        send(mk_body(1'b1, 1'b0, b1));
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL et_valid got=%0b want=1", valid_out); end
        total++; if (data_out[31:0] !== 32'h0) begin bad++; $display("FAIL et_low got=%h want=0", data_out[31:0]); end
        total++;
        if (data_out[91:32] !== {h, b1}) begin
            bad++; $display("FAIL et_high got=%h want=%h", data_out[91:32], {h, b1});
        end
        total++; if (err_out !== 1'b1) begin bad++; $display("FAIL et_err got=%0b want=1", err_out); end
        @(negedge clk);
    endtask

    task automatic test_head_mid_packet();
        logic [27:0] ha, hb;
        logic [31:0] b1, b2;
        pulse_reset();
        ha = 28'($urandom()); hb = 28'($urandom()); b1 = $urandom(); b2 = $urandom();
        send(mk_head(1'b0, 1'b0, 4'h1, ha));
        send(mk_body(1'b0, 1'b0, $urandom()));
        send(mk_head(1'b0, 1'b0, 4'hE, hb));
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL hm_noout got=%0b want=0", valid_out); end
        send(mk_body(1'b0, 1'b0, b1));
        send(mk_body(1'b1, 1'b0, b2));
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL hm_valid got=%0b want=1", valid_out); end
        total++;
        if (data_out !== ref_data(hb, b1, b2, 3)) begin
            bad++; $display("FAIL hm_data got=%h want=%h", data_out, ref_data(hb, b1, b2, 3));
        end
        total++; if (dst_out !== 4'hE) begin bad++; $display("FAIL hm_dst got=%h want=e", dst_out); end
        total++; if (err_out !== 1'b1) begin bad++; $display("FAIL hm_err got=%0b want=1", err_out); end
        @(negedge clk);
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL hm_once got=%0b want=0", valid_out); end
    endtask

    task automatic test_reset_mid_packet();
        pulse_reset();
        send(mk_head(1'b0, 1'b0, 4'h7, 28'($urandom())));
        send(mk_body(1'b0, 1'b0, $urandom()));
        #2 rst_n = 1'b0;
        #1;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0b want=0", valid_out); end
        total++; if (data_out !== '0) begin bad++; $display("FAIL rm_data got=%h want=0", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rm_after[%0d] got=%0b want=0", i, valid_out); end
        end
        ready_in = 1'b0;
        send(mk_head(1'b0, 1'b0, 4'h7, 28'($urandom())));
        send(mk_body(1'b0, 1'b0, $urandom()));
        send(mk_body(1'b1, 1'b0, $urandom()));
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL rh_pre got=%0b want=1", valid_out); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rh_async got=%0b want=0", valid_out); end
        total++; if (dst_out !== '0) begin bad++; $display("FAIL rh_dst got=%h want=0", dst_out); end
        @(negedge clk);
        rst_n    = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [WI-1:0] fl[3];
        logic [27:0] h;
        logic [31:0] b1, b2;
        logic [WO-1:0] e;
        logic [AW-1:0] d;
        pulse_reset();
        ready_in = 1'b1;
        for (int p = 0; p < 4; p++) begin
            h = 28'($urandom()); b1 = $urandom(); b2 = $urandom(); d = 4'($urandom());
            e = ref_data(h, b1, b2, 3);
            fl[0] = mk_head(1'b0, 1'b0, d, h);
            fl[1] = mk_body(1'b0, 1'b0, b1);
            fl[2] = mk_body(1'b1, 1'b0, b2);
            for (int f = 0; f < 3; f++) begin
                data_in  = fl[f];
                valid_in = 1'b1;
                #1;
                total++;
                if (ready_out !== 1'b1) begin
                    bad++; $display("FAIL b2b_ready[%0d.%0d] got=%0b want=1", p, f, ready_out);
                end
                @(negedge clk);
            end
            total++;
            if (valid_out !== 1'b1 || data_out !== e || dst_out !== d) begin
                bad++;
                $display("FAIL b2b_pkt[%0d] got=%0b/%h/%h want=1/%h/%h", p, valid_out, data_out,
                         dst_out, e, d);
            end
        end
        valid_in = 1'b0;
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL b2b_err got=%0b want=0", err_out); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [WI-1:0] stream[$];
        pkt_t exp_q[$];
        pkt_t got;
        pkt_t want;
        logic exp_err;
        int idx;
        int cycles;
        pulse_reset();
        exp_err = 1'b0;
        for (int p = 0; p < 25; p++) begin
            logic [27:0] h;
            logic [31:0] b1, b2;
            logic [AW-1:0] d;
            logic [VW-1:0] v;
            int r;
            int n;
            h = 28'($urandom()); b1 = $urandom(); b2 = $urandom(); d = 4'($urandom());
`ifdef DEPACKETIZER_VC_FILTER_EN
            v = '0;
`else
            v = VW'($urandom());
`endif
            r = $urandom_range(0, 5);
            n = (r < 3) ? 3 : r - 2;
            if (n < 3) exp_err = 1'b1;
            stream.push_back(mk_head(n == 1, v, d, h));
            if (n > 1) stream.push_back(mk_body(n == 2, v, b1));
            if (n > 2) stream.push_back(mk_body(1'b1, v, b2));
            exp_q.push_back('{d: ref_data(h, b1, b2, n), dst: d, vc: v});
        end
        idx    = 0;
        cycles = 0;
        while ((idx < stream.size() || exp_q.size() > 0) && cycles < 3000) begin
            ready_in = ($urandom_range(0, 3) != 0);
            if (idx < stream.size() && $urandom_range(0, 4) != 0) begin
                data_in  = stream[idx];
                valid_in = 1'b1;
            end else begin
                data_in  = {1'b0, 35'($urandom())};
                valid_in = 1'($urandom_range(0, 1));
            end
            #1;
            if (valid_out && ready_in) begin
                got = '{d: data_out, dst: dst_out, vc: vc_out};
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_extra got=%h want=none", data_out);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++; $display("FAIL rnd_pkt got=%h want=%h", got, want);
                    end
                end
            end
            if (valid_in && ready_out && data_in[WI-1]) idx++;
            @(negedge clk);
            cycles++;
        end
        valid_in = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL rnd_timeout left=%0d want=0", exp_q.size());
        end
        total++; if (err_out !== exp_err) begin bad++; $display("FAIL rnd_err got=%0b want=%0b", err_out, exp_err); end
    endtask

`ifdef DEPACKETIZER_VC_FILTER_EN
    task automatic test_vc_filter();
        logic [27:0] h;
        logic [31:0] b1, b2;
        pulse_reset();
        send(mk_head(1'b0, 1'b1, 4'h4, 28'($urandom())));
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL vf_v0 got=%0b want=0", valid_out); end
        send(mk_body(1'b0, 1'b1, $urandom()));
        send(mk_body(1'b1, 1'b1, $urandom()));
        for (int i = 0; i < 3; i++) begin
            total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL vf_valid[%0d] got=%0b want=0", i, valid_out); end
            @(negedge clk);
        end
        total++; if (err_out !== 1'b1) begin bad++; $display("FAIL vf_err got=%0b want=1", err_out); end
        h = 28'($urandom()); b1 = $urandom(); b2 = $urandom();
        send(mk_head(1'b0, 1'b0, 4'h4, h));
        send(mk_body(1'b0, 1'b0, b1));
        send(mk_body(1'b1, 1'b0, b2));
        total++;
        if (valid_out !== 1'b1 || data_out !== ref_data(h, b1, b2, 3)) begin
            bad++; $display("FAIL vf_pkt got=%0b/%h want=1/%h", valid_out, data_out, ref_data(h, b1, b2, 3));
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_three_flit();
        test_backpressure();
        test_body_in_idle();
        test_early_tail();
        test_head_mid_packet();
        test_reset_mid_packet();
        test_back_to_back();
        test_random();
`ifdef DEPACKETIZER_VC_FILTER_EN
        test_vc_filter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/depacketizer_3.md
Name: depacketizer_3

Overview:
- Receive-side stage that sits directly downstream of the NoC egress port and consumes flits in the format the packetizer stages produce.
- Reassembles a 1..3-flit packet into one wide data word and registers it with the destination and VC fields.
- Presents the result on a valid/ready port to the consuming module.
- Detects malformed flit sequences and recovers from them.

Parameters:
- ADDRESS_WIDTH, 4, width of the dst field in the head flit
- VC_ADDRESS_WIDTH, 1, width of the VC field in every flit
- WIDTH_IN, 36, flit width
- WIDTH_OUT, 92, reassembled data width; must satisfy WIDTH_OUT <= HEAD_PAYLOAD + 2*BODY_PAYLOAD
- ASSIGNED_VC, 0, the VC this port owns; used only with the optional feature

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset: asynchronous, active-low
- data_in  in  WIDTH_IN  flit from NoC
- valid_in  in  1  flit strobe
- ready_out  out  1  flit accepted when valid_in & ready_out
- data_out  out  WIDTH_OUT  reassembled data, MSB-first
- dst_out  out  ADDRESS_WIDTH  dst field of the head flit
- vc_out  out  VC_ADDRESS_WIDTH  VC field of the head flit
- valid_out  out  1  packet available
- ready_in  in  1  consumer ready
- err_out  out  1  sticky protocol-error flag

Behaviour:
Flit field layout (MSB down):
- Bit W-1: flit valid. Bit W-2: head. Bit W-3: tail. Then VC.
- Head flit: then dst, then HEAD_PAYLOAD = W-3-ADDRESS_WIDTH-VC_ADDRESS_WIDTH bits. Default: 28.
- Body flit: BODY_PAYLOAD = W-3-VC_ADDRESS_WIDTH bits. Default: 32.
- NUM_FLITS = 1 if WIDTH_OUT <= HEAD_PAYLOAD, else 1 + ceil((WIDTH_OUT-HEAD_PAYLOAD)/BODY_PAYLOAD).
- A flit counts only if valid_in & ready_out & flit-valid bit; a flit with flit-valid=0 is consumed and ignored.
- Data placement:
  - Head payload fills data_out[WIDTH_OUT-1 -: HEAD_PAYLOAD].
  - Each body flit fills the next lower slice.
  - The last flit's payload is MSB-aligned; its LSB padding is discarded.

FSM states: IDLE, BODY, HOLD. Reset puts the FSM in IDLE.
- IDLE:
  - Head with tail and NUM_FLITS=1 -> HOLD.
  - Head without tail -> BODY, flit count=1.
  - Body flit -> dropped, err_out set, stay in IDLE.
- BODY:
  - Body flit: store the slice and increment the count.
  - Leave for HOLD on the tail flit or when count reaches NUM_FLITS.
  - Tail earlier than NUM_FLITS: unfilled bits are 0, err_out set.
  - Count reaches NUM_FLITS without tail: treated as tail, err_out set.
  - Head flit arrives: partial packet discarded, restart from this head, err_out set.
- HOLD:
  - valid_out=1; data_out, dst_out and vc_out stable.
  - When ready_in=1, the packet is consumed.
  - A head flit presented in the same cycle is accepted (-> BODY, or stays in HOLD if it is a single-flit packet). Otherwise -> IDLE.
- ready_out = (state != HOLD) | ready_in. This is a combinational path from ready_in only.
- Latency: tail flit accepted in cycle N -> valid_out=1 in cycle N+1.
- Throughput: back-to-back multi-flit packets at 1 flit/cycle with no bubble.

Reset values:
- valid_out=0, err_out=0, data_out=0, dst_out=0, vc_out=0, assembly buffer=0.
- Reset mid-packet discards the partial packet; no output is produced for it.
- err_out clears only on reset.

Optional Feature:
Macro DEPACKETIZER_VC_FILTER_EN.
- Defined: any counted flit whose VC field != ASSIGNED_VC is consumed and dropped, err_out is set, and the FSM state is unchanged.
- Undefined: VC is not checked; vc_out reports whatever the head flit carried.

Decomposition:
- Package lynx_flit_pkg holds:
  - field-offset localparams (VALID_BIT, HEAD_BIT, TAIL_BIT offsets);
  - payload-width and NUM_FLITS functions of (WIDTH_IN, ADDRESS_WIDTH, VC_ADDRESS_WIDTH, WIDTH_OUT);
  - the state enum.
- One combinational sub-module, flit_field_decode, splits a flit into valid/head/tail/vc/dst/payload.

Test Plan:
- 3-flit packet (defaults), ready_in=1:
  - Stimulus: head {1,1,0,0,4'h5,28'hABCDEF1}, body {1,0,0,0,32'h12345678}, tail {1,0,1,0,32'h9ABCDEF0}.
  - Response: one cycle after the tail, data_out=92'hABCDEF1_12345678_9ABCDEF0, dst_out=5, err_out=0.
- Backpressure:
  - Stimulus: ready_in=0 after the tail, then the next head presented.
  - Response: ready_out=0, outputs hold for 5 cycles. Raising ready_in accepts the head in the same cycle; the second packet completes correctly.
- Body flit while IDLE:
  - Response: flit dropped, err_out=1, no valid_out; the next well-formed packet is still delivered.
- Early tail (2 flits):
  - Response: data_out[31:0]=0, upper 60 bits correct, err_out=1.
- Head mid-packet, plus reset:
  - Stimulus: second head arrives after 1 body flit.
  - Response: first packet lost; second delivered intact.
  - Stimulus: rst_n pulsed low mid-packet.
  - Response: valid_out=0 immediately, and no output for the packet.
- With DEPACKETIZER_VC_FILTER_EN:
  - Stimulus: packet on VC 1 with ASSIGNED_VC=0.
  - Response: all flits dropped, err_out=1, valid_out stays 0.
